cnn_layer_accel_awe_stride_ctrl: RTL and testbench

Frame-level sequencer for the AWE stride picker. The stride picker only decimates along a row; this block adds the row dimension. It accepts a per-layer frame config, drops non-stride rows, and re-arms the picker at every row start so each row's column phase begins at column 0. It also counts the picker's output samples to flag end-of-row and end-of-frame. It sits between the AWE input stream and the picker.

---
 rtl/cnn_layer_accel_awe_stride_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_cnn_layer_accel_awe_stride_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_accel_awe_stride_ctrl.sv
// Frame-level row sequencer for the AWE stride picker: drops non-stride rows and re-arms the picker per row.
// Optional perf counters are enabled with CNN_LAYER_ACCEL_AWE_STRIDE_CTRL_PERF_EN.
module cnn_layer_accel_awe_stride_ctrl #(
    parameter int unsigned C_COL_WIDTH    = 10,
    parameter int unsigned C_ROW_WIDTH    = 10,
    parameter int unsigned C_STRIDE_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [C_COL_WIDTH-1:0]    cfg_num_cols,
    input  logic [C_ROW_WIDTH-1:0]    cfg_num_rows,
    input  logic [C_STRIDE_WIDTH-1:0] cfg_stride,
    input  logic                      abort,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      picker_config_valid,
    output logic [C_STRIDE_WIDTH-1:0] picker_stride_size,
    output logic                      picker_datain_valid,
    input  logic                      picker_dataout_valid,
    output logic                      out_row_last,
    output logic                      frame_done,
    output logic                      busy
`ifdef CNN_LAYER_ACCEL_AWE_STRIDE_CTRL_PERF_EN
    ,
    output logic [31:0]               perf_stall_cycles,
    output logic [31:0]               perf_drop_samples
`endif
);

    localparam int unsigned CW1 = C_COL_WIDTH + 1;
    localparam int unsigned RW1 = C_ROW_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_RUN,
        S_ROW_SYNC,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                    state_q, state_d;
    logic [C_COL_WIDTH-1:0]    num_cols_q, num_cols_d;
    logic [C_ROW_WIDTH-1:0]    num_rows_q, num_rows_d;
    logic [C_STRIDE_WIDTH-1:0] stride_q, stride_d;
    logic [C_COL_WIDTH-1:0]    col_cnt_q, col_cnt_d;
    logic [C_ROW_WIDTH-1:0]    row_cnt_q, row_cnt_d;
    logic [C_STRIDE_WIDTH-1:0] row_phase_q, row_phase_d;
    logic [C_COL_WIDTH-1:0]    exp_out_q, exp_out_d;
    logic [C_ROW_WIDTH-1:0]    kept_rows_q, kept_rows_d;
    logic [C_COL_WIDTH-1:0]    out_cnt_q, out_cnt_d;
    logic [C_ROW_WIDTH-1:0]    rows_done_q, rows_done_d;
    logic                      cfg_ready_q, cfg_ready_d;
    logic                      in_ready_q, in_ready_d;
    logic                      pcfg_valid_q, pcfg_valid_d;
    logic                      frame_done_q, frame_done_d;
    logic                      busy_q, busy_d;

    logic                      row_keep;
    logic                      in_fire;
    logic                      cfg_fire;
    logic                      out_active;
    logic                      out_hit;
    logic [CW1-1:0]            col_sum;
    logic [CW1-1:0]            col_div;
    logic [RW1-1:0]            row_sum;
    logic [RW1-1:0]            row_div;

    assign row_keep   = (row_phase_q == '0);
    assign in_fire    = in_valid && in_ready_q;
    assign cfg_fire   = cfg_valid && cfg_ready_q;
    // Picker outputs may still land during ROW_SYNC/DRAIN; abort discards them.
    assign out_active = ((state_q == S_RUN) || (state_q == S_ROW_SYNC) || (state_q == S_DRAIN)) && !abort;
    assign out_hit    = out_active && picker_dataout_valid && (out_cnt_q == (exp_out_q - C_COL_WIDTH'(1)));

    // ceil(n/(stride+1)) as (n+stride)/(stride+1), widened to avoid overflow
    assign col_sum = CW1'(num_cols_q) + CW1'(stride_q);
    assign col_div = CW1'(stride_q) + CW1'(1);
    assign row_sum = RW1'(num_rows_q) + RW1'(stride_q);
    assign row_div = RW1'(stride_q) + RW1'(1);

    assign cfg_ready           = cfg_ready_q;
    assign in_ready            = in_ready_q;
    assign picker_config_valid = pcfg_valid_q;
    assign picker_stride_size  = stride_q;
    assign picker_datain_valid = in_fire && row_keep;
    assign out_row_last        = out_hit;
    assign frame_done          = frame_done_q;
    assign busy                = busy_q;

    always_comb begin
        state_d     = state_q;
        num_cols_d  = num_cols_q;
        num_rows_d  = num_rows_q;
        stride_d    = stride_q;
        col_cnt_d   = col_cnt_q;
        row_cnt_d   = row_cnt_q;
        row_phase_d = row_phase_q;
        exp_out_d   = exp_out_q;
        kept_rows_d = kept_rows_q;
        out_cnt_d   = out_cnt_q;
        rows_done_d = rows_done_q;

        if (out_active && picker_dataout_valid) begin
            if (out_hit) begin
                out_cnt_d   = '0;
                rows_done_d = rows_done_q + C_ROW_WIDTH'(1);
            end else begin
                out_cnt_d = out_cnt_q + C_COL_WIDTH'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_fire) begin
                    num_cols_d = cfg_num_cols;
                    num_rows_d = cfg_num_rows;
                    stride_d   = cfg_stride;
                    state_d    = S_CFG;
                end
            end
            S_CFG: begin
                col_cnt_d   = '0;
                row_cnt_d   = '0;
                row_phase_d = '0;
                out_cnt_d   = '0;
                rows_done_d = '0;
                exp_out_d   = C_COL_WIDTH'(col_sum / col_div);
                kept_rows_d = C_ROW_WIDTH'(row_sum / row_div);
                state_d     = S_RUN;
            end
            S_RUN: begin
                if (in_fire) begin
                    if (col_cnt_q == (num_cols_q - C_COL_WIDTH'(1))) begin
                        col_cnt_d   = '0;
                        row_cnt_d   = row_cnt_q + C_ROW_WIDTH'(1);
                        row_phase_d = (row_phase_q == stride_q) ? '0 : (row_phase_q + C_STRIDE_WIDTH'(1));
                        state_d     = (row_cnt_q == (num_rows_q - C_ROW_WIDTH'(1))) ? S_DRAIN : S_ROW_SYNC;
                    end else begin
                        col_cnt_d = col_cnt_q + C_COL_WIDTH'(1);
                    end
                end
            end
            S_ROW_SYNC: state_d = S_RUN;
            S_DRAIN: begin
                if (rows_done_q == kept_rows_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            col_cnt_d   = '0;
            row_cnt_d   = '0;
            row_phase_d = '0;
            out_cnt_d   = '0;
            rows_done_d = '0;
        end

        // Status outputs registered from the next state
        cfg_ready_d  = (state_d == S_IDLE);
        in_ready_d   = (state_d == S_RUN);
        pcfg_valid_d = (state_d == S_CFG) || (state_d == S_ROW_SYNC);
        frame_done_d = (state_d == S_DONE);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            num_cols_q   <= '0;
            num_rows_q   <= '0;
            stride_q     <= '0;
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            row_phase_q  <= '0;
            exp_out_q    <= '0;
            kept_rows_q  <= '0;
            out_cnt_q    <= '0;
            rows_done_q  <= '0;
            cfg_ready_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            pcfg_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_cols_q   <= num_cols_d;
            num_rows_q   <= num_rows_d;
            stride_q     <= stride_d;
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            row_phase_q  <= row_phase_d;
            exp_out_q    <= exp_out_d;
            kept_rows_q  <= kept_rows_d;
            out_cnt_q    <= out_cnt_d;
            rows_done_q  <= rows_done_d;
            cfg_ready_q  <= cfg_ready_d;
            in_ready_q   <= in_ready_d;
            pcfg_valid_q <= pcfg_valid_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

`ifdef CNN_LAYER_ACCEL_AWE_STRIDE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_drop_q, perf_drop_d;

    // Saturating stall / dropped-sample counters, cleared per accepted config
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_drop_d  = perf_drop_q;
        if (cfg_fire) begin
            perf_stall_d = '0;
            perf_drop_d  = '0;
        end else begin
            if ((state_q == S_RUN) && !in_valid && (perf_stall_q != '1)) begin
                perf_stall_d = perf_stall_q + 32'd1;
            end
            if (in_fire && !row_keep && (perf_drop_q != '1)) begin
                perf_drop_d = perf_drop_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_drop_q  <= perf_drop_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_drop_samples = perf_drop_q;
`endif

endmodule

// File: tb/tb_cnn_layer_accel_awe_stride_ctrl.sv
// Bench for cnn_layer_accel_awe_stride_ctrl: table vectors, random frames, abort and async-reset sequences.
module tb_cnn_layer_accel_awe_stride_ctrl;

    localparam int unsigned CW = 10;
    localparam int unsigned RW = 10;
    localparam int unsigned SW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_num_cols;
    logic [RW-1:0] cfg_num_rows;
    logic [SW-1:0] cfg_stride;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic          picker_config_valid;
    logic [SW-1:0] picker_stride_size;
    logic          picker_datain_valid;
    logic          picker_dataout_valid;
    logic          out_row_last;
    logic          frame_done;
    logic          busy;
`ifdef CNN_LAYER_ACCEL_AWE_STRIDE_CTRL_PERF_EN
    logic [31:0]   perf_stall_cycles;
    logic [31:0]   perf_drop_samples;
`endif

    cnn_layer_accel_awe_stride_ctrl #(
        .C_COL_WIDTH(CW), .C_ROW_WIDTH(RW), .C_STRIDE_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_num_cols(cfg_num_cols), .cfg_num_rows(cfg_num_rows), .cfg_stride(cfg_stride),
        .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
        .picker_config_valid(picker_config_valid), .picker_stride_size(picker_stride_size),
        .picker_datain_valid(picker_datain_valid), .picker_dataout_valid(picker_dataout_valid),
        .out_row_last(out_row_last), .frame_done(frame_done), .busy(busy)
`ifdef CNN_LAYER_ACCEL_AWE_STRIDE_CTRL_PERF_EN
        ,
        .perf_stall_cycles(perf_stall_cycles), .perf_drop_samples(perf_drop_samples)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int cols; int rows; int s; int bubble; bit mid;
        int e_fwd; int e_picks; int e_last; int e_cfgv; int e_lat;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;

    int m_cols, m_rows, m_s, bubble_pct, abort_at, mid_cfg_at;
    int acc_idx, cyc, first_acc_cyc, last_acc_cyc, done_cyc;
    int fwd_cnt, pick_cnt, last_cnt, cfgv_cnt, done_cnt;
    bit pend_out, pend_last, aborted;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference counts derived directly from the row/column stride rules
    function automatic int count_kept(input int n, input int s);
        int k = 0;
        for (int i = 0; i < n; i++) if (i % (s + 1) == 0) k++;
        return k;
    endfunction

    // One clock: picker model (1-cycle latency), stimulus, and per-cycle checks
    task automatic cycle();
        bit vin, el, keep;
        int row, col;
        @(posedge clk);
        #1;
        cyc++;
        picker_dataout_valid = pend_out;
        el = pend_last;
        vin = (bubble_pct == 0) ? 1'b1 : ($urandom_range(99) >= 32'(bubble_pct));
        in_valid = vin;
        abort = (abort_at >= 0) && in_ready && vin && (acc_idx == abort_at);
        cfg_valid = (cyc == mid_cfg_at);
        if (cfg_valid) begin
            cfg_num_cols = 10'd3;
            cfg_num_rows = 10'd9;
            cfg_stride   = 2'd3;
        end
        #1;
        if (cfg_valid) chk("cfg_ready_mid_frame", cfg_ready, 0);
        if (busy) chk("stride_size", picker_stride_size, m_s);
        if (picker_dataout_valid && !aborted && !abort) begin
            chk("out_row_last", out_row_last, el);
            pick_cnt++;
        end else begin
            chk("out_row_last_quiet", out_row_last, 0);
        end
        if (in_valid && in_ready) begin
            row  = acc_idx / m_cols;
            col  = acc_idx % m_cols;
            keep = (row % (m_s + 1) == 0);
            chk("datain_valid", picker_datain_valid, keep);
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
            acc_idx++;
            pend_out  = keep && (col % (m_s + 1) == 0);
            pend_last = pend_out && (col == ((m_cols - 1) / (m_s + 1)) * (m_s + 1));
        end else begin
            chk("no_forward", picker_datain_valid, 0);
            pend_out  = 1'b0;
            pend_last = 1'b0;
        end
        if (abort) aborted = 1'b1;
        fwd_cnt  += int'(picker_datain_valid);
        last_cnt += int'(out_row_last);
        cfgv_cnt += int'(picker_config_valid);
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic start_frame(input int c, input int r, input int s);
        int w = 0;
        m_cols = c; m_rows = r; m_s = s;
        acc_idx = 0; first_acc_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
        fwd_cnt = 0; pick_cnt = 0; last_cnt = 0; cfgv_cnt = 0; done_cnt = 0;
        pend_out = 1'b0; pend_last = 1'b0; aborted = 1'b0;
        @(posedge clk);
        #1;
        picker_dataout_valid = 1'b0;
        abort = 1'b0;
        in_valid = 1'b0;
        #1;
        while (!cfg_ready && w < 20) begin
            @(posedge clk);
            #2;
            w++;
        end
        chk("cfg_ready_idle", cfg_ready, 1);
        cfg_valid    = 1'b1;
        cfg_num_cols = CW'(c);
        cfg_num_rows = RW'(r);
        cfg_stride   = SW'(s);
    endtask

    task automatic run_frame(input int c, input int r, input int s, input int b, input bit mid);
        bubble_pct = b;
        abort_at   = -1;
        start_frame(c, r, s);
        mid_cfg_at = mid ? cyc + 6 : -1;
        for (int k = 0; k < 3000 && done_cnt == 0; k++) cycle();
        if (done_cnt == 0) chk("frame_timeout", 0, 1);
        cycle();
        chk("post_done_busy", busy, 0);
        chk("post_done_cfg_ready", cfg_ready, 1);
        chk("single_frame_done", done_cnt, 1);
    endtask

    vec_t tbl[6];
    int kr, ppr, lat;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{cols:8, rows:4, s:1, bubble:0,  mid:0, e_fwd:16, e_picks:8,  e_last:2, e_cfgv:4, e_lat:2};
        tbl[1] = '{cols:5, rows:3, s:0, bubble:0,  mid:0, e_fwd:15, e_picks:15, e_last:3, e_cfgv:3, e_lat:3};
        tbl[2] = '{cols:7, rows:7, s:2, bubble:50, mid:0, e_fwd:21, e_picks:9,  e_last:3, e_cfgv:7, e_lat:3};
        tbl[3] = '{cols:8, rows:4, s:1, bubble:0,  mid:1, e_fwd:16, e_picks:8,  e_last:2, e_cfgv:4, e_lat:2};
        tbl[4] = '{cols:1, rows:1, s:0, bubble:0,  mid:0, e_fwd:1,  e_picks:1,  e_last:1, e_cfgv:1, e_lat:3};
        tbl[5] = '{cols:6, rows:5, s:3, bubble:0,  mid:0, e_fwd:12, e_picks:4,  e_last:2, e_cfgv:5, e_lat:2};

        rst = 1'b0; cfg_valid = 1'b0; cfg_num_cols = '0; cfg_num_rows = '0; cfg_stride = '0;
        abort = 1'b0; in_valid = 1'b0; picker_dataout_valid = 1'b0;
        cyc = 0; abort_at = -1; mid_cfg_at = -1; m_cols = 1; m_rows = 1; m_s = 0; bubble_pct = 0;
        #2;
        chk("reset_cfg_ready", cfg_ready, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_stride", picker_stride_size, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_pcfg_valid", picker_config_valid, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #2;
        chk("idle_cfg_ready", cfg_ready, 1);

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i].cols, tbl[i].rows, tbl[i].s, tbl[i].bubble, tbl[i].mid);
            chk($sformatf("v%0d_fwd", i), fwd_cnt, tbl[i].e_fwd);
            chk($sformatf("v%0d_picks", i), pick_cnt, tbl[i].e_picks);
            chk($sformatf("v%0d_row_last", i), last_cnt, tbl[i].e_last);
            chk($sformatf("v%0d_cfg_pulses", i), cfgv_cnt, tbl[i].e_cfgv);
            chk($sformatf("v%0d_done_latency", i), done_cyc - last_acc_cyc, tbl[i].e_lat);
            chk($sformatf("v%0d_accepted", i), acc_idx, tbl[i].cols * tbl[i].rows);
            if (tbl[i].bubble == 0)
                chk($sformatf("v%0d_row_gaps", i), last_acc_cyc - first_acc_cyc,
                    tbl[i].cols * tbl[i].rows - 1 + tbl[i].rows - 1);
        end

        for (int i = 0; i < 6; i++) begin
            int c, r, s;
            c = int'($urandom_range(1, 12));
            r = int'($urandom_range(1, 8));
            s = int'($urandom_range(0, 3));
            run_frame(c, r, s, 30, 1'b0);
            kr  = count_kept(r, s);
            ppr = count_kept(c, s);
            lat = (((r - 1) % (s + 1) == 0) && ((c - 1) % (s + 1) == 0)) ? 3 : 2;
            chk($sformatf("r%0d_fwd", i), fwd_cnt, kr * c);
            chk($sformatf("r%0d_picks", i), pick_cnt, kr * ppr);
            chk($sformatf("r%0d_row_last", i), last_cnt, kr);
            chk($sformatf("r%0d_cfg_pulses", i), cfgv_cnt, r);
            chk($sformatf("r%0d_done_latency", i), done_cyc - last_acc_cyc, lat);
        end

        // Abort on sample 10 of an 8x4 frame, then a normal 2x2 frame
        bubble_pct = 0;
        start_frame(8, 4, 1);
        abort_at = 10;
        for (int k = 0; k < 200 && !aborted; k++) cycle();
        chk("abort_seen", aborted, 1);
        abort_at = -1;
        cycle();
        chk("abort_busy", busy, 0);
        chk("abort_cfg_ready", cfg_ready, 1);
        repeat (3) cycle();
        chk("abort_no_done", done_cnt, 0);
        run_frame(2, 2, 0, 0, 1'b0);
        chk("post_abort_fwd", fwd_cnt, 4);
        chk("post_abort_row_last", last_cnt, 2);

        // Asynchronous reset between edges in the middle of RUN
        bubble_pct = 0;
        start_frame(8, 4, 1);
        repeat (6) cycle();
        chk("pre_rst_busy", busy, 1);
        @(posedge clk);
        #3;
        picker_dataout_valid = 1'b1;
        rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_cfg_ready", cfg_ready, 0);
        chk("arst_pcfg_valid", picker_config_valid, 0);
        chk("arst_stride", picker_stride_size, 0);
        chk("arst_datain_valid", picker_datain_valid, 0);
        chk("arst_row_last", out_row_last, 0);
        chk("arst_frame_done", frame_done, 0);
        picker_dataout_valid = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #2;
        chk("arst_release_cfg_ready", cfg_ready, 1);
        chk("arst_release_busy", busy, 0);
`ifdef CNN_LAYER_ACCEL_AWE_STRIDE_CTRL_PERF_EN
        chk("arst_perf_stall", int'(perf_stall_cycles), 0);
        chk("arst_perf_drop", int'(perf_drop_samples), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
